iceboard_tx_arbiter: RTL and testbench

//  Shares the single iceboardcontrol UART transmit byte path among N_REQ byte-stream

---
 rtl/vidor_uart_pkg.sv | 21 ++
 rtl/uart_rr_pick.sv | 32 +++
 rtl/iceboard_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_iceboard_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vidor_uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// default header tag / abort byte, and the header-byte builder.
package vidor_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_ABORT   = 2'd3
  } arb_state_t;

  localparam logic [3:0] DEF_HDR_TAG    = 4'hA;
  localparam logic [7:0] DEF_ABORT_BYTE = 8'hFF;

  // Source header: tag in the upper nibble, requester index in the lower.
  function automatic logic [7:0] build_header(input logic [3:0] tag,
                                              input logic [3:0] src);
    return {tag, src};
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first valid requester found scanning from rr_ptr
// upward (mod N_REQ). Purely combinational.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any
);

  int unsigned idx;

  // Scan N_REQ slots starting at rr_ptr; the first valid one wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % N_REQ;
      if (!any && req_valid[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/iceboard_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART TX byte path among
// N_REQ byte-stream requesters. Each packet is prefixed with a one-byte
// source header; a watchdog aborts an owner that stalls mid-packet.
module iceboard_tx_arbiter
  import vidor_uart_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [3:0]  HDR_TAG    = DEF_HDR_TAG,
  parameter logic [7:0]  ABORT_BYTE = DEF_ABORT_BYTE
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               abort_pulse
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t       state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    g_idx;
  logic [WW-1:0]    wd_cnt;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic             own_valid;
  logic             own_last;
  logic [7:0]       own_data;
  logic             owner_xfer;
  logic             wd_expire;
  logic [IW-1:0]    rr_next;
  logic [3:0]       hdr_idx;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .pick      (pick),
    .pick_idx  (pick_idx),
    .any       (pick_any)
  );

  assign own_valid  = req_valid[g_idx];
  assign own_last   = req_last[g_idx];
  assign own_data   = req_data[{g_idx, 3'b000} +: 8];
  assign owner_xfer = (state == ST_PAYLOAD) && own_valid && tx_ready;
  assign rr_next    = (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
  assign hdr_idx    = 4'(g_idx);
  assign busy       = (state != ST_IDLE);

  // Abort only when the owner is still idle at the last allowed count.
  assign wd_expire  = (TIMEOUT > 0) && (state == ST_PAYLOAD) && !own_valid &&
                      (wd_cnt == WW'(TIMEOUT - 1));

  // Arbitration FSM: owner selection, packet lock and round-robin pointer.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      g_idx  <= '0;
      grant  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant <= pick;
            g_idx <= pick_idx;
            state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (tx_ready) state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (owner_xfer && own_last) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= rr_next;
          end else if (wd_expire) begin
            state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (tx_ready) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= rr_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Watchdog: counts owner-idle cycles in PAYLOAD, saturating; held at zero
  // outside PAYLOAD so every packet starts with a fresh count.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wd_cnt <= '0;
    end else if (TIMEOUT == 0 || state != ST_PAYLOAD || owner_xfer) begin
      wd_cnt <= '0;
    end else if (!own_valid && wd_cnt != WW'(TIMEOUT)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Output muxes: header/abort bytes come from registered state, payload is
  // a combinational pass-through of the owner.
  always_comb begin
    tx_data     = '0;
    tx_valid    = 1'b0;
    req_ready   = '0;
    abort_pulse = 1'b0;
    case (state)
      ST_HEADER: begin
        tx_data  = build_header(HDR_TAG, hdr_idx);
        tx_valid = 1'b1;
      end
      ST_PAYLOAD: begin
        tx_data   = own_data;
        tx_valid  = own_valid;
        req_ready = grant & {N_REQ{tx_ready}};
      end
      ST_ABORT: begin
        tx_data     = ABORT_BYTE;
        tx_valid    = 1'b1;
        abort_pulse = tx_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iceboard_tx_arbiter.sv
// Directed bench for iceboard_tx_arbiter with a TX-side scoreboard.
module tb_iceboard_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] grant;
    logic       chk_grant;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready  = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;
  logic           abort_pulse;

  int             checks = 0;
  int             errors = 0;
  exp_t           sb[$];

  logic [8:0]     src_mem [N][64];
  int unsigned    head [N];
  int unsigned    tail [N];
  logic [N-1:0]   xfer = '0;
  logic           tx_ready_en = 1'b0;
  int unsigned    cyc = 0;
  int unsigned    last_hs_cyc = 0;
  int unsigned    abort_gap = 0;
  int unsigned    abort_cnt = 0;

  always #5 clk = ~clk;

  iceboard_tx_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .grant         (grant),
    .busy          (busy),
    .abort_pulse   (abort_pulse)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input int unsigned i, input logic [7:0] d, input logic last);
    src_mem[i][tail[i] % 64] = {last, d};
    tail[i]++;
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic [3:0] g, input logic cg);
    exp_t e;
    e.data = d;
    e.grant = g;
    e.chk_grant = cg;
    sb.push_back(e);
  endtask

  task automatic wait_sb_size(input int n, input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (sb.size() == n) break;
    end
    check(tag, 64'(sb.size()), 64'(n));
  endtask

  // Requester streams and tx sink: drive on negedge, observe 1 time unit later.
  always @(negedge clk) begin
    cyc++;
    for (int unsigned i = 0; i < N; i++)
      if (xfer[i]) head[i]++;
    for (int unsigned i = 0; i < N; i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[8*i +: 8]} = src_mem[i][head[i] % 64];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
    tx_ready = tx_ready_en;
    #1;
    xfer = req_valid & req_ready;
    if (tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        check("tx_unexpected", {56'b0, tx_data}, 64'h1FF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tx_data", {56'b0, tx_data}, {56'b0, e.data});
        if (e.chk_grant) check("tx_grant", {60'b0, grant}, {60'b0, e.grant});
      end
      if (abort_pulse) begin
        abort_gap = cyc - last_hs_cyc;
        abort_cnt++;
      end
      last_hs_cyc = cyc;
    end else if (abort_pulse) begin
      check("abort_without_transfer", {62'b0, tx_valid, tx_ready}, 64'h3);
    end
  end

  initial begin
    for (int unsigned i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("reset_outputs", {req_ready, tx_data, tx_valid, grant, busy, abort_pulse}, '0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tx_ready_en = 1'b1;

    // Idle: nothing requested for 100 cycles.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      check("idle_quiet", {tx_valid, grant, busy}, '0);
    end

    // Single packet from requester 1.
    @(posedge clk);
    expect_tx(8'hA1, 4'b0010, 1'b1);
    expect_tx(8'h11, 4'b0010, 1'b1);
    expect_tx(8'h22, 4'b0010, 1'b1);
    expect_tx(8'h33, 4'b0010, 1'b1);
    enq(1, 8'h11, 1'b0);
    enq(1, 8'h22, 1'b0);
    enq(1, 8'h33, 1'b1);
    wait_sb_size(0, 50, "single_drain");
    @(negedge clk);
    #2;
    check("single_idle_after", {busy, grant}, '0);
    check("single_rr_ptr", 64'(dut.rr_ptr), 64'd2);

    // Fairness: req0 and req2 always pending, rr_ptr=2 so req2 goes first.
    @(posedge clk);
    for (int unsigned k = 0; k < 3; k++) begin
      enq(2, 8'h20 + 8'(2*k), 1'b0);
      enq(2, 8'h21 + 8'(2*k), 1'b1);
      enq(0, 8'h40 + 8'(2*k), 1'b0);
      enq(0, 8'h41 + 8'(2*k), 1'b1);
      expect_tx(8'hA2, 4'b0100, 1'b1);
      expect_tx(8'h20 + 8'(2*k), 4'b0100, 1'b1);
      expect_tx(8'h21 + 8'(2*k), 4'b0100, 1'b1);
      expect_tx(8'hA0, 4'b0001, 1'b1);
      expect_tx(8'h40 + 8'(2*k), 4'b0001, 1'b1);
      expect_tx(8'h41 + 8'(2*k), 4'b0001, 1'b1);
    end
    wait_sb_size(0, 200, "fair_drain");
    @(negedge clk);
    #2;
    check("fair_rr_ptr", 64'(dut.rr_ptr), 64'd1);

    // Sink backpressure far longer than the watchdog limit: no abort.
    @(posedge clk);
    expect_tx(8'hA1, 4'b0010, 1'b1);
    for (int unsigned k = 0; k < 4; k++) begin
      enq(1, 8'h51 + 8'(k), (k == 3));
      expect_tx(8'h51 + 8'(k), 4'b0010, 1'b1);
    end
    wait_sb_size(2, 50, "bp_reach_stall");
    tx_ready_en = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    #2;
    check("bp_stall_hold", {busy, grant, tx_valid, tx_data}, {1'b1, 4'b0010, 1'b1, 8'h53});
    @(posedge clk);
    tx_ready_en = 1'b1;
    wait_sb_size(0, 50, "bp_drain");
    check("bp_no_abort", 64'(abort_cnt), 64'd0);

    // Watchdog: req3 stalls after one byte, req0 waits behind it.
    @(posedge clk);
    enq(3, 8'h55, 1'b0);
    enq(0, 8'h66, 1'b1);
    expect_tx(8'hA3, 4'b1000, 1'b1);
    expect_tx(8'h55, 4'b1000, 1'b1);
    expect_tx(8'hFF, 4'b0000, 1'b0);
    expect_tx(8'hA0, 4'b0001, 1'b1);
    expect_tx(8'h66, 4'b0001, 1'b1);
    wait_sb_size(0, 100, "wd_drain");
    // Transfer edge to ABORT entry is TO cycles; the abort byte is seen one
    // observation later than the byte handshake's own observation point.
    check("wd_abort_gap", 64'(abort_gap), 64'(TO + 1));
    check("wd_abort_cnt", 64'(abort_cnt), 64'd1);

    // Async reset mid-packet: req2 owns and is stalled by the sink.
    @(posedge clk);
    expect_tx(8'hA2, 4'b0100, 1'b1);
    for (int unsigned k = 0; k < 4; k++) begin
      enq(2, 8'h81 + 8'(k), (k == 3));
      expect_tx(8'h81 + 8'(k), 4'b0100, 1'b1);
    end
    wait_sb_size(4, 50, "rst_reach_payload");
    tx_ready_en = 1'b0;
    enq(0, 8'h77, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("rst_pre_busy", {busy, grant}, {1'b1, 4'b0100});
    #1 rst_n = 1'b0;
    #1;
    check("rst_outputs_async", {req_ready, tx_data, tx_valid, grant, busy, abort_pulse}, '0);
    sb.delete();
    // rr_ptr back at 0: req0 first, then req2's untouched bytes as a new packet.
    expect_tx(8'hA0, 4'b0001, 1'b1);
    expect_tx(8'h77, 4'b0001, 1'b1);
    expect_tx(8'hA2, 4'b0100, 1'b1);
    for (int unsigned k = 0; k < 4; k++)
      expect_tx(8'h81 + 8'(k), 4'b0100, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tx_ready_en = 1'b1;
    wait_sb_size(0, 100, "rst_drain");
    check("rst_no_abort", 64'(abort_cnt), 64'd1);

    repeat (5) @(negedge clk);
    #2;
    check("final_idle", {busy, tx_valid, grant}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
